// File: rtl/convolver_pkg.sv
// convolver_pkg: shared sizing constants and helpers for the convolver datapath
package convolver_pkg;
  localparam int KERNEL_SIZE = 3;
  function automatic int clog2(input int v);
    int r;
    for (r = 0; (1 << r) < v; r++) begin
    end
    return r;
  endfunction
  function automatic int level_count(input int m, input int l);
    return (m + (1 << l) - 1) >> l;
  endfunction
  localparam int NUM_TAPS = KERNEL_SIZE ** 2;
  localparam int TREE_OPERANDS = NUM_TAPS + 1;
  localparam int TREE_LEVELS = clog2(TREE_OPERANDS);
endpackage

// File: rtl/adder_tree_accumulator_if.sv
// adder_tree_accumulator_if: product/bias input and result output handshakes
interface adder_tree_accumulator_if #(
  parameter int DATA_WIDTH = 32,
  parameter int KERNEL_SIZE = 3
);
  logic [(KERNEL_SIZE ** 2) * DATA_WIDTH-1:0] products;
  logic [DATA_WIDTH-1:0] bias;
  logic in_valid;
  logic in_ready;
  logic [DATA_WIDTH-1:0] result;
  logic out_valid;
  logic out_ready;
  modport master(output products, bias, in_valid, out_ready, input in_ready, result, out_valid);
  modport slave(input products, bias, in_valid, out_ready, output in_ready, result, out_valid);
endinterface

// File: rtl/adder_tree_level.sv
// adder_tree_level: one pairwise-add rank of the tree with its valid bit
module adder_tree_level #(
  parameter int DATA_WIDTH = 32,
  parameter int IN_COUNT = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic advance_i,
  input  logic valid_i,
  input  logic [IN_COUNT*DATA_WIDTH-1:0] data_i,
  output logic valid_o,
  output logic [((IN_COUNT+1)/2)*DATA_WIDTH-1:0] data_o
);
  localparam int OUT_COUNT = (IN_COUNT + 1) / 2;
  logic [OUT_COUNT*DATA_WIDTH-1:0] data_d, data_q;
  logic valid_q;
  for (genvar j = 0; j < OUT_COUNT; j++) begin : g
    if (2 * j + 1 < IN_COUNT) begin : g_add
      assign data_d[j*DATA_WIDTH +: DATA_WIDTH] = data_i[2*j*DATA_WIDTH +: DATA_WIDTH]
                                                + data_i[(2*j+1)*DATA_WIDTH +: DATA_WIDTH];
    end else begin : g_pass
      assign data_d[j*DATA_WIDTH +: DATA_WIDTH] = data_i[2*j*DATA_WIDTH +: DATA_WIDTH];
    end
  end
  // Rank moves only on advance; data of a bubble keeps its old contents
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q <= '0;
    end else if (advance_i) begin
      valid_q <= valid_i;
      if (valid_i) data_q <= data_d;
    end
  end
  assign valid_o = valid_q;
  assign data_o = data_q;
endmodule

// File: rtl/adder_tree_accumulator.sv
// adder_tree_accumulator: pipelined sum of all kernel products plus bias
module adder_tree_accumulator
  import convolver_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int KERNEL_SIZE = convolver_pkg::KERNEL_SIZE
) (
  input logic clk,
  input logic reset,
  adder_tree_accumulator_if.slave bus
);
  localparam int M = KERNEL_SIZE ** 2 + 1;
  localparam int LEVELS = clog2(M);
  logic advance;
  assign advance = !bus.out_valid | bus.out_ready;
  assign bus.in_ready = advance;
  for (genvar l = 0; l < LEVELS; l++) begin : g
    localparam int IC = level_count(M, l);
    localparam int OC = level_count(M, l + 1);
    logic [IC*DATA_WIDTH-1:0] d_in;
    logic [OC*DATA_WIDTH-1:0] d_out;
    logic v_in, v_out;
    if (l == 0) begin : g_first
      assign d_in = {bus.bias, bus.products};
      assign v_in = bus.in_valid;
    end else begin : g_next
      assign d_in = g[l-1].d_out;
      assign v_in = g[l-1].v_out;
    end
    adder_tree_level #(.DATA_WIDTH(DATA_WIDTH), .IN_COUNT(IC)) u_level (
      .clk(clk),
      .reset(reset),
      .advance_i(advance),
      .valid_i(v_in),
      .data_i(d_in),
      .valid_o(v_out),
      .data_o(d_out)
    );
  end
  assign bus.out_valid = g[LEVELS-1].v_out;
  assign bus.result = g[LEVELS-1].d_out;
endmodule

// File: tb/tb_adder_tree_accumulator.sv
// tb_adder_tree_accumulator: scenario tasks against a queue-based sum model
module tb_adder_tree_accumulator;
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;
  adder_tree_accumulator_if #(.DATA_WIDTH(32), .KERNEL_SIZE(3)) b3();
  adder_tree_accumulator_if #(.DATA_WIDTH(32), .KERNEL_SIZE(1)) b1();
  adder_tree_accumulator #(.DATA_WIDTH(32), .KERNEL_SIZE(3)) dut3 (.clk(clk), .reset(reset), .bus(b3.slave));
  adder_tree_accumulator #(.DATA_WIDTH(32), .KERNEL_SIZE(1)) dut1 (.clk(clk), .reset(reset), .bus(b1.slave));
  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];

  function automatic logic [31:0] ref3(input logic [287:0] p, input logic [31:0] b);
    logic [31:0] s;
    s = b;
    for (int i = 0; i < 9; i++) s = s + p[i*32 +: 32];
    return s;
  endfunction

  function automatic logic [287:0] fill(input logic [31:0] v);
    logic [287:0] p;
    for (int i = 0; i < 9; i++) p[i*32 +: 32] = v;
    return p;
  endfunction

  function automatic logic [287:0] rand_p();
    logic [287:0] p;
    for (int i = 0; i < 9; i++) p[i*32 +: 32] = ($urandom % 8 == 0) ? 32'hFFFFFFFF : $urandom;
    return p;
  endfunction

  task automatic test_reset();
    b3.in_valid = 0; b3.out_ready = 1; b3.products = '0; b3.bias = '0;
    b1.in_valid = 0; b1.out_ready = 1; b1.products = '0; b1.bias = '0;
    #2 reset = 1;
    #1;
    total++; if (b3.out_valid !== 1'b0) begin bad++; $display("FAIL reset_ov3 got=%b want=0", b3.out_valid); end
    total++; if (b3.in_ready !== 1'b1) begin bad++; $display("FAIL reset_ir3 got=%b want=1", b3.in_ready); end
    total++; if (b3.result !== 32'd0) begin bad++; $display("FAIL reset_res3 got=%h want=0", b3.result); end
    total++; if (b1.out_valid !== 1'b0) begin bad++; $display("FAIL reset_ov1 got=%b want=0", b1.out_valid); end
    total++; if (b1.in_ready !== 1'b1) begin bad++; $display("FAIL reset_ir1 got=%b want=1", b1.in_ready); end
    @(negedge clk);
    @(negedge clk);
    reset = 0;
  endtask

  task automatic test_latency(input logic [287:0] p, input logic [31:0] b, input logic [31:0] expv, input string nm);
    int acc_c, hits, hit_c;
    logic [31:0] r;
    acc_c = -1; hits = 0; hit_c = -1; r = 'x;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      b3.in_valid = (c == 0); b3.products = p; b3.bias = b; b3.out_ready = 1;
      #1;
      if (b3.in_valid && b3.in_ready) acc_c = c;
      if (b3.out_valid) begin hits++; hit_c = c; r = b3.result; end
    end
    b3.in_valid = 0;
    total++; if (hits != 1 || acc_c != 0 || hit_c - acc_c != 4) begin
      bad++; $display("FAIL %s_latency got hits=%0d lat=%0d want hits=1 lat=4", nm, hits, hit_c - acc_c);
    end
    total++; if (r !== expv) begin bad++; $display("FAIL %s_value got=%h want=%h", nm, r, expv); end
  endtask

  task automatic test_back_to_back();
    int sent, got, stall;
    logic [31:0] held;
    sent = 0; got = 0; stall = 0; held = '0;
    for (int c = 0; c < 40 && got < 6; c++) begin
      @(negedge clk);
      b3.in_valid = (sent < 6); b3.products = fill(32'(sent + 1)); b3.bias = 0;
      b3.out_ready = !(b3.out_valid && got == 1 && stall < 3);
      #1;
      if (!b3.out_ready) begin
        stall++;
        total++; if (b3.in_ready !== 1'b0) begin bad++; $display("FAIL b2b_stall_ready got=%b want=0", b3.in_ready); end
        if (stall == 1) held = b3.result;
        else begin
          total++; if (b3.result !== held || b3.out_valid !== 1'b1) begin
            bad++; $display("FAIL b2b_hold got=%h/%b want=%h/1", b3.result, b3.out_valid, held);
          end
        end
      end
      if (b3.in_valid && b3.in_ready) sent++;
      if (b3.out_valid && b3.out_ready) begin
        total++; if (b3.result !== 32'(9 * (got + 1))) begin
          bad++; $display("FAIL b2b_result%0d got=%0d want=%0d", got + 1, b3.result, 9 * (got + 1));
        end
        got++;
      end
    end
    b3.in_valid = 0; b3.out_ready = 1;
    total++; if (got != 6 || stall != 3) begin bad++; $display("FAIL b2b_count got=%0d/%0d want=6/3", got, stall); end
  endtask

  task automatic test_reset_flight();
    int seen;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      b3.in_valid = 1; b3.products = fill(32'(c + 11)); b3.bias = 1; b3.out_ready = 1;
    end
    @(negedge clk);
    b3.in_valid = 0;
    @(negedge clk);
    #1;
    total++; if (b3.out_valid !== 1'b1) begin bad++; $display("FAIL flight_pre got=%b want=1", b3.out_valid); end
    reset = 1;
    #1;
    total++; if (b3.out_valid !== 1'b0) begin bad++; $display("FAIL flight_ov got=%b want=0", b3.out_valid); end
    total++; if (b3.result !== 32'd0) begin bad++; $display("FAIL flight_res got=%h want=0", b3.result); end
    total++; if (b3.in_ready !== 1'b1) begin bad++; $display("FAIL flight_ir got=%b want=1", b3.in_ready); end
    @(negedge clk);
    reset = 0;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      if (b3.out_valid) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL flight_ghost got=%0d want=0", seen); end
    test_latency(fill(32'd2), 32'd3, 32'd21, "post_reset");
  endtask

  task automatic test_k1();
    int acc_c, hit_c, hits, got;
    logic [31:0] r, a, b;
    acc_c = -1; hit_c = -1; hits = 0; r = 'x;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      b1.in_valid = (c == 0); b1.products = 32'd7; b1.bias = 32'd5; b1.out_ready = 1;
      #1;
      if (b1.in_valid && b1.in_ready) acc_c = c;
      if (b1.out_valid) begin hits++; hit_c = c; r = b1.result; end
    end
    total++; if (hits != 1 || hit_c - acc_c != 1) begin bad++; $display("FAIL k1_latency got hits=%0d lat=%0d want 1/1", hits, hit_c - acc_c); end
    total++; if (r !== 32'd12) begin bad++; $display("FAIL k1_value got=%0d want=12", r); end
    exp_q.delete();
    got = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      a = $urandom; b = $urandom;
      b1.in_valid = (c < 12); b1.products = a; b1.bias = b; b1.out_ready = 1;
      #1;
      if (b1.in_valid && b1.in_ready) exp_q.push_back(a + b);
      if (c >= 1 && c <= 12) begin
        total++; if (b1.out_valid !== 1'b1) begin bad++; $display("FAIL k1_stream_gap cycle=%0d got=%b want=1", c, b1.out_valid); end
      end
      if (b1.out_valid && b1.out_ready) begin
        got++;
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL k1_extra got=%h want=none", b1.result); end
        else begin
          r = exp_q.pop_front();
          if (b1.result !== r) begin bad++; $display("FAIL k1_stream got=%h want=%h", b1.result, r); end
        end
      end
    end
    b1.in_valid = 0;
    total++; if (got != 12 || exp_q.size() != 0) begin bad++; $display("FAIL k1_count got=%0d want=12", got); end
  endtask

  task automatic test_random();
    logic [287:0] p;
    logic [31:0] bv, e, prev_r;
    bit prev_stall;
    exp_q.delete();
    prev_stall = 0; prev_r = '0;
    for (int c = 0; c < 420; c++) begin
      @(negedge clk);
      p = rand_p(); bv = $urandom;
      b3.in_valid = (c < 400) && ($urandom % 4 != 0); b3.products = p; b3.bias = bv;
      b3.out_ready = (c >= 400) || ($urandom % 3 != 0);
      #1;
      if (prev_stall) begin
        total++; if (b3.out_valid !== 1'b1 || b3.result !== prev_r) begin
          bad++; $display("FAIL rand_hold got=%h/%b want=%h/1", b3.result, b3.out_valid, prev_r);
        end
      end
      if (b3.in_valid && b3.in_ready) exp_q.push_back(ref3(p, bv));
      if (b3.out_valid && b3.out_ready) begin
        total++;
        if (exp_q.size() == 0) begin bad++; $display("FAIL rand_extra got=%h want=none", b3.result); end
        else begin
          e = exp_q.pop_front();
          if (b3.result !== e) begin bad++; $display("FAIL rand_result got=%h want=%h", b3.result, e); end
        end
      end
      prev_stall = b3.out_valid && !b3.out_ready;
      prev_r = b3.result;
    end
    b3.in_valid = 0; b3.out_ready = 1;
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL rand_lost got=%0d want=0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_latency(fill(32'd1), 32'd0, 32'd9, "ones");
    begin
      logic [287:0] p;
      for (int i = 0; i < 9; i++) p[i*32 +: 32] = 32'(i + 1);
      test_latency(p, 32'd100, 32'd145, "taps");
    end
    test_latency(fill(32'hFFFFFFFF), 32'd0, 32'hFFFFFFF7, "wrap");
    test_back_to_back();
    test_reset_flight();
    test_k1();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
